// File: rtl/lzc_byte_feeder.sv
// Word-to-byte feeder for the leading-zero counter.
// Buffers words in a FIFO and streams them MSB byte first, with an idle gap.
module lzc_byte_feeder #(
  parameter int WIDTH = 8,
  parameter int WORD  = 4,
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [WIDTH*WORD-1:0]    IN_DATA,
  input  logic                     IN_MODE,
  output logic [WIDTH-1:0]         DATA,
  output logic                     IVALID,
  output logic                     MODE,
  output logic                     BUSY,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int PW = $clog2(DEPTH);
  localparam int DW = WIDTH * WORD;
  localparam int BW = $clog2(WORD + 1);
  localparam int GW = $clog2(GAP + 1);

  localparam logic [PW:0]   FULL   = (PW + 1)'(DEPTH);
  localparam logic [BW-1:0] LAST_B = BW'(WORD - 1);
  localparam logic [GW-1:0] LAST_G = GW'(GAP - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [DW:0]     r_mem [DEPTH];
  logic [PW-1:0]   r_wr;
  logic [PW-1:0]   r_rd;
  logic [PW:0]     r_count;
  logic [1:0]      r_state;
  logic [DW-1:0]   r_sh;
  logic [BW-1:0]   r_bcnt;
  logic [GW-1:0]   r_gcnt;
  logic [WIDTH-1:0] r_data;
  logic            r_ivalid;
  logic            r_mode;

  logic            w_ready;
  logic            w_push;
  logic            w_pop;
  logic [DW:0]     w_head;

  // Ready looks only at occupancy, so a full FIFO refuses even while popping.
  assign w_ready = (r_count != FULL);
  assign w_push  = IN_VALID & w_ready;
  assign w_pop   = (r_state == S_IDLE) & (r_count != '0);
  assign w_head  = r_mem[r_rd];

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wr] <= {IN_MODE, IN_DATA};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_sh     <= '0;
      r_bcnt   <= '0;
      r_gcnt   <= '0;
      r_data   <= '0;
      r_ivalid <= 1'b0;
      r_mode   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_data   <= w_head[DW-1 -: WIDTH];
            r_sh     <= w_head[DW-1:0] << WIDTH;
            r_mode   <= w_head[DW];
            r_ivalid <= 1'b1;
            r_bcnt   <= '0;
            r_state  <= S_SEND;
          end
        end
        S_SEND: begin
          if (r_bcnt == LAST_B) begin
            r_data   <= '0;
            r_ivalid <= 1'b0;
            r_gcnt   <= '0;
            r_state  <= S_GAP;
          end else begin
            r_data <= r_sh[DW-1 -: WIDTH];
            r_sh   <= r_sh << WIDTH;
            r_bcnt <= r_bcnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_gcnt == LAST_G) r_state <= S_IDLE;
          else                  r_gcnt  <= r_gcnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign IN_READY = w_ready;
  assign DATA     = r_data;
  assign IVALID   = r_ivalid;
  assign MODE     = r_mode;
  assign COUNT    = r_count;
  assign BUSY     = (r_state != S_IDLE) | (r_count != '0);

endmodule

// File: tb/tb_lzc_byte_feeder.sv
// Bench for lzc_byte_feeder: cycle table, back-pressure, wrap and reset cases.
// A byte-stream monitor checks every delivered word against the push log.
module tb_lzc_byte_feeder;

  localparam int GAP = 2;

  logic        CLK;
  logic        RST_N;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_DATA;
  logic        IN_MODE;
  logic [7:0]  DATA;
  logic        IVALID;
  logic        MODE;
  logic        BUSY;
  logic [2:0]  COUNT;

  lzc_byte_feeder #(.WIDTH(8), .WORD(4), .DEPTH(4), .GAP(GAP)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .IN_DATA(IN_DATA), .IN_MODE(IN_MODE),
    .DATA(DATA), .IVALID(IVALID), .MODE(MODE),
    .BUSY(BUSY), .COUNT(COUNT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask

  typedef struct {
    logic       v;
    logic       m;
    logic [31:0] d;
    logic       e_iv;
    logic [7:0] e_data;
    logic       e_mode;
    logic       e_busy;
    logic [2:0] e_cnt;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic v, input logic m, input logic [31:0] d,
                     input logic iv, input logic [7:0] dt,
                     input logic md, input logic bz, input logic [2:0] cn);
    vec_t r;
    r.v = v; r.m = m; r.d = d;
    r.e_iv = iv; r.e_data = dt; r.e_mode = md;
    r.e_busy = bz; r.e_cnt = cn;
    tv.push_back(r);
  endtask

  function automatic logic [31:0] wd(input int k);
    return {8'(k), 8'hA5, 8'(k * 3), 8'(255 - k)};
  endfunction

  function automatic logic wm(input int k);
    return k[0];
  endfunction

  // push log and output monitor
  logic [31:0] sb_d[$];
  logic        sb_m[$];
  int          starts[$];
  int          cyc = 0;
  int          run = 0;
  int          last_end = -100;
  int          nwords = 0;
  logic [31:0] acc_w;
  logic        run_m;

  always @(posedge CLK) begin
    if (RST_N && IN_VALID && IN_READY) begin
      sb_d.push_back(IN_DATA);
      sb_m.push_back(IN_MODE);
    end
  end

  always @(negedge CLK) begin
    cyc++;
    if (!RST_N) begin
      run = 0;
      last_end = -100;
      sb_d.delete();
      sb_m.delete();
    end else begin
      chk("count_le_depth", 32'(COUNT <= 3'd4), 1);
      if (IVALID) begin
        if (run == 0) begin
          chk("gap_len", 32'((cyc - last_end) > GAP), 1);
          starts.push_back(cyc);
          run_m = MODE;
          acc_w = '0;
        end else begin
          chk("mode_stable", 32'(MODE), 32'(run_m));
        end
        acc_w = {acc_w[23:0], DATA};
        run++;
      end else begin
        chk("data_idle", 32'(DATA), 0);
        if (run > 0) begin
          chk("run_len", run, 4);
          if (sb_d.size() == 0) begin
            chk("stray_word", sb_d.size(), 1);
          end else begin
            chk("word", acc_w, sb_d.pop_front());
            chk("word_mode", 32'(run_m), 32'(sb_m.pop_front()));
            nwords++;
          end
          run = 0;
          last_end = cyc;
        end
      end
    end
  end

  task automatic push_one(input logic m, input logic [31:0] d);
    logic acc;
    int t;
    t = 0;
    IN_VALID = 1'b1; IN_MODE = m; IN_DATA = d;
    forever begin
      acc = IN_READY;
      @(negedge CLK);
      t++;
      if (acc) break;
      if (t > 50) begin
        chk("push_timeout", t, 0);
        break;
      end
    end
    IN_VALID = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((BUSY || run != 0) && t < 300) begin
      @(negedge CLK);
      t++;
    end
    chk("drain_busy", 32'(BUSY), 0);
    chk("drain_log_empty", sb_d.size(), 0);
  endtask

  int t3_cnt[10] = '{1, 1, 2, 3, 4, 4, 4, 4, 3, 4};

  initial begin
    int i;
    int s0;
    int n0;
    logic acc;

    IN_VALID = 1'b0; IN_MODE = 1'b0; IN_DATA = '0;
    RST_N = 1'b1;
    #2 RST_N = 1'b0;
    #1;
    chk("rst_ivalid", 32'(IVALID), 0);
    chk("rst_data", 32'(DATA), 0);
    chk("rst_mode", 32'(MODE), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_count", 32'(COUNT), 0);
    chk("rst_ready", 32'(IN_READY), 1);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    // single word, then a MODE=1 word followed by an all-zero word
    add(1, 0, 32'h0000_0180, 0, 8'h00, 0, 1, 1);
    add(0, 0, 0, 1, 8'h00, 0, 1, 0);
    add(0, 0, 0, 1, 8'h00, 0, 1, 0);
    add(0, 0, 0, 1, 8'h01, 0, 1, 0);
    add(0, 0, 0, 1, 8'h80, 0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 0, 0);
    add(0, 0, 0, 0, 8'h00, 0, 0, 0);
    add(1, 1, 32'h40FF_FFFF, 0, 8'h00, 0, 1, 1);
    add(1, 0, 32'h0000_0000, 1, 8'h40, 1, 1, 1);
    add(0, 0, 0, 1, 8'hFF, 1, 1, 1);
    add(0, 0, 0, 1, 8'hFF, 1, 1, 1);
    add(0, 0, 0, 1, 8'hFF, 1, 1, 1);
    add(0, 0, 0, 0, 8'h00, 1, 1, 1);
    add(0, 0, 0, 0, 8'h00, 1, 1, 1);
    add(0, 0, 0, 0, 8'h00, 1, 1, 1);
    add(0, 0, 0, 1, 8'h00, 0, 1, 0);
    add(0, 0, 0, 1, 8'h00, 0, 1, 0);
    add(0, 0, 0, 1, 8'h00, 0, 1, 0);
    add(0, 0, 0, 1, 8'h00, 0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 1, 0);
    add(0, 0, 0, 0, 8'h00, 0, 0, 0);

    for (int k = 0; k < tv.size(); k++) begin
      IN_VALID = tv[k].v; IN_MODE = tv[k].m; IN_DATA = tv[k].d;
      @(negedge CLK);
      chk($sformatf("tv%0d_ivalid", k), 32'(IVALID), 32'(tv[k].e_iv));
      chk($sformatf("tv%0d_data", k), 32'(DATA), 32'(tv[k].e_data));
      chk($sformatf("tv%0d_mode", k), 32'(MODE), 32'(tv[k].e_mode));
      chk($sformatf("tv%0d_busy", k), 32'(BUSY), 32'(tv[k].e_busy));
      chk($sformatf("tv%0d_count", k), 32'(COUNT), 32'(tv[k].e_cnt));
      chk($sformatf("tv%0d_ready", k), 32'(IN_READY),
          32'(tv[k].e_cnt < 3'd4));
    end
    IN_VALID = 1'b0;
    chk("t2_period", starts[starts.size()-1] - starts[starts.size()-2], 7);
    chk("t2_words", nwords, 3);

    // back-pressure: six words with IN_VALID held high
    s0 = starts.size();
    n0 = nwords;
    i = 0;
    for (int c = 0; c < 10; c++) begin
      IN_VALID = (i < 6); IN_MODE = wm(i); IN_DATA = wd(i);
      acc = IN_READY & IN_VALID;
      @(negedge CLK);
      if (acc) i++;
      chk($sformatf("t3_count%0d", c), 32'(COUNT), t3_cnt[c]);
      chk($sformatf("t3_ready%0d", c), 32'(IN_READY),
          32'(t3_cnt[c] < 4));
    end
    IN_VALID = 1'b0;
    chk("t3_accepted", i, 6);

    // ten more words through several pointer wraps
    for (int k = 6; k < 16; k++) push_one(wm(k), wd(k));
    drain();
    chk("t4_words", nwords - n0, 16);
    for (int k = s0 + 1; k < starts.size(); k++)
      chk($sformatf("t4_period%0d", k - s0), starts[k] - starts[k-1], 7);

    // reset in the middle of a word with two more queued
    push_one(0, 32'h1122_3344);
    push_one(1, 32'h5566_7788);
    push_one(0, 32'h99AA_BBCC);
    @(negedge CLK);
    chk("t5_pre_ivalid", 32'(IVALID), 1);
    chk("t5_pre_byte", 32'(DATA), 32'h33);
    chk("t5_pre_count", 32'(COUNT), 2);
    #2 RST_N = 1'b0;
    #1;
    chk("t5_ivalid", 32'(IVALID), 0);
    chk("t5_data", 32'(DATA), 0);
    chk("t5_count", 32'(COUNT), 0);
    chk("t5_busy", 32'(BUSY), 0);
    @(negedge CLK);
    @(negedge CLK);
    #2 RST_N = 1'b1;
    @(negedge CLK);
    n0 = nwords;
    push_one(1, 32'h00C3_0001);
    drain();
    chk("t5_words", nwords - n0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lzc_byte_feeder.md
# lzc_byte_feeder

Upstream stage of the leading-zero counter. It accepts whole words (WORD bytes each, plus a per-word MODE bit) over a valid/ready handshake, buffers them in a small FIFO, and serializes each word MSB-byte-first onto the counter's byte interface (DATA/IVALID/MODE). After each word it inserts a fixed IVALID-low gap so the counter can finish and re-arm before the next word.

## Interface
- WIDTH, 8: bits per byte on the output bus.
- WORD, 4: bytes per word.
- DEPTH, 4: FIFO entries, power of two, ≥2.
- GAP, 2: idle cycles (IVALID low) after each word, ≥1.

- CLK  in  1  clock, rising edge.
- RST_N  in  1  reset, asynchronous, active-low.
- IN_VALID  in  1  word offered.
- IN_READY  out  1  FIFO can accept; high when count < DEPTH.
- IN_DATA  in  WIDTH*WORD  word; bits [WIDTH*WORD-1 -: WIDTH] are sent first.
- IN_MODE  in  1  0 = count all WORD bytes, 1 = stop at first nonzero byte.
- DATA  out  WIDTH  current byte to counter.
- IVALID  out  1  DATA valid.
- MODE  out  1  mode of the word being (or last) sent.
- BUSY  out  1  high when state ≠ IDLE or FIFO non-empty.
- COUNT  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- FIFO: DEPTH entries of {IN_MODE, IN_DATA}; wr/rd pointers wrap modulo DEPTH; separate occupancy counter.
- Push when IN_VALID && IN_READY. IN_READY depends on COUNT only (not on a same-cycle pop): full FIFO refuses input even if popping that cycle.
- Push and pop in same cycle: COUNT unchanged, both pointers advance.
- FSM states IDLE, SEND, GAP:
  - IDLE: if FIFO non-empty, pop head into shift register, MODE <= head mode, byte counter <= 0, go SEND. Else stay.
  - SEND: IVALID=1, DATA = top WIDTH bits of shift register. Each edge shift left by WIDTH and increment byte counter; on edge where byte counter = WORD-1, go GAP with gap counter <= 0.
  - GAP: IVALID=0, DATA=0, MODE holds. Gap counter increments each edge; on edge where it = GAP-1, go IDLE.
- Feeder always sends all WORD bytes regardless of MODE; early termination is the counter's job.
- Outputs DATA, IVALID, MODE are registered (no combinational path from IN_*).
- All-zero words are sent normally.

## Timing
- Reset (asynchronous, immediate): state IDLE, FIFO emptied, COUNT=0, IN_READY=1, DATA=0, IVALID=0, MODE=0, BUSY=0. Reset mid-word aborts the word; IVALID drops without waiting for a clock.
- Word pushed at edge E into empty FIFO in IDLE: load at E+1; IVALID high for cycles between E+1 and E+1+WORD; first byte visible after E+1 (2-edge push-to-first-byte latency).
- Load at edge L: IVALID high L..L+WORD, low L+WORD..L+WORD+GAP, IDLE for one cycle, next load at L+WORD+GAP+1. Sustained period WORD+GAP+1 cycles per word (7 with defaults).
- IVALID never high for more or fewer than WORD consecutive cycles; successive words always separated by ≥GAP+1 low cycles.
- COUNT reflects post-edge occupancy; BUSY falls the cycle after the last GAP cycle if FIFO empty.
- Pointer wrap: entry order preserved across wrap; no entry lost or duplicated.

## Test plan
- Reset then push {MODE=0, 0x0000_0180}: DATA = 0x00,0x00,0x01,0x80 on 4 consecutive IVALID cycles starting 2 edges after push; IVALID low 2 cycles; MODE=0 throughout; BUSY low afterwards.
- Push {MODE=1, 0x40FF_FFFF} then {MODE=0, 0x0000_0000}: first word bytes 0x40,0xFF,0xFF,0xFF with MODE=1; second word starts exactly 7 cycles after first load with MODE=0, four 0x00 bytes.
- IN_VALID held high with 6 distinct words from empty: w0 loaded immediately, w1–w4 fill FIFO (COUNT=4, IN_READY=0), w5 accepted on the edge after w1 is loaded; output order w0..w5, each with period 7.
- Fill FIFO, then 10 more words through several pointer wraps: output sequence equals input sequence, COUNT never exceeds 4, no IVALID run ≠ 4.
- Assert RST_N low during the 3rd byte of a word with 2 words queued: IVALID and DATA go 0 immediately, COUNT=0; after release, push one word → it is sent complete and nothing stale appears.
- IN_VALID high while FIFO full with a pop occurring the same edge: word not accepted that edge (IN_READY=0), accepted the following edge, COUNT back to 4.
